// File: rtl/bp_cce_mem_requester_pkg.sv
// Shared types for the cce_mem requester: processor config lookup, memory
// message layout, and the error bit indices reported on error_o.
package bp_cce_mem_requester_pkg;

  typedef enum logic [0:0] {
    e_bp_default_cfg = 1'b0
  } bp_params_e;

  typedef struct packed {
    int paddr_width;
    int cce_block_width;
    int lce_id_width;
  } bp_proc_param_s;

  // Widths for each supported processor configuration
  function automatic bp_proc_param_s bp_get_cfg(bp_params_e cfg);
    bp_proc_param_s p;
    case (cfg)
      e_bp_default_cfg: p = '{paddr_width: 40, cce_block_width: 64, lce_id_width: 4};
      default:          p = '{paddr_width: 40, cce_block_width: 64, lce_id_width: 4};
    endcase
    return p;
  endfunction

  localparam bp_proc_param_s default_cfg_gp = bp_get_cfg(e_bp_default_cfg);
  localparam int paddr_width_gp     = default_cfg_gp.paddr_width;
  localparam int cce_block_width_gp = default_cfg_gp.cce_block_width;
  localparam int lce_id_width_gp    = default_cfg_gp.lce_id_width;

  typedef enum logic [3:0] {
    e_mem_msg_rd    = 4'b0000,
    e_mem_msg_wr    = 4'b0001,
    e_mem_msg_uc_rd = 4'b0010,
    e_mem_msg_uc_wr = 4'b0011,
    e_mem_msg_pre   = 4'b0100
  } bp_mem_msg_e;

  typedef enum logic [2:0] {
    e_mem_msg_size_1  = 3'b000,
    e_mem_msg_size_2  = 3'b001,
    e_mem_msg_size_4  = 3'b010,
    e_mem_msg_size_8  = 3'b011,
    e_mem_msg_size_16 = 3'b100,
    e_mem_msg_size_32 = 3'b101,
    e_mem_msg_size_64 = 3'b110
  } bp_mem_msg_size_e;

  typedef struct packed {
    logic [lce_id_width_gp-1:0] lce_id;
    logic [2:0]                 way_id;
  } bp_mem_msg_payload_s;

  typedef struct packed {
    bp_mem_msg_payload_s         payload;
    bp_mem_msg_size_e            size;
    logic [paddr_width_gp-1:0]   addr;
    bp_mem_msg_e                 msg_type;
  } bp_cce_mem_msg_header_s;

  typedef struct packed {
    logic [cce_block_width_gp-1:0] data;
    bp_cce_mem_msg_header_s        header;
  } bp_cce_mem_msg_s;

  // Bit positions inside error_o
  typedef enum logic [0:0] {
    e_req_err_unexpected = 1'b0,
    e_req_err_timeout    = 1'b1
  } bp_req_err_e;

endpackage

// File: rtl/bp_cce_mem_requester_credits.sv
// In-flight command credit counter plus sticky protocol error flags.
// Optional watchdog enabled by defining BP_CCE_MEM_REQUESTER_TIMEOUT_EN.
module bp_cce_mem_requester_credits
  import bp_cce_mem_requester_pkg::*;
 #(parameter int max_outstanding_p = 4
  , parameter int timeout_p         = 1024
  , localparam int credit_width_lp  = $clog2(max_outstanding_p + 1)
  )
  (input  logic                       clk_i
  , input  logic                       reset_i
  , input  logic                       send_i
  , input  logic                       yumi_i
  , input  logic                       resp_v_i
  , output logic [credit_width_lp-1:0] credits_o
  , output logic [1:0]                 error_o
  );

  logic [credit_width_lp-1:0] credits_reg, credits_next;
  logic                       unexpected_reg;
  logic                       timeout_err;
  logic                       dec;

  // A consume with no credits is already flagged as unexpected; never wrap below zero
  assign dec = yumi_i & (credits_reg != '0);

  // Send and consume in the same cycle cancel out
  always_comb begin
    credits_next = credits_reg;
    if (send_i & ~dec)
      credits_next = credits_reg + credit_width_lp'(1);
    else if (~send_i & dec)
      credits_next = credits_reg - credit_width_lp'(1);
  end

  // Credit register and sticky unexpected-response flag
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      credits_reg    <= '0;
      unexpected_reg <= 1'b0;
    end else begin
      credits_reg <= credits_next;
      if (resp_v_i & (credits_reg == '0))
        unexpected_reg <= 1'b1;
    end
  end

`ifdef BP_CCE_MEM_REQUESTER_TIMEOUT_EN
  localparam int wd_width_lp = (timeout_p > 1) ? $clog2(timeout_p) : 1;
  localparam logic [wd_width_lp-1:0] wd_limit_lp = wd_width_lp'(timeout_p - 1);

  logic [wd_width_lp-1:0] wd_reg, wd_next;
  logic                   timeout_reg;
  logic                   wd_count_en;

  // Only count while something is outstanding and no progress is being made
  assign wd_count_en = (credits_reg != '0) & ~yumi_i;

  // Watchdog counts up and saturates at the limit
  always_comb begin
    wd_next = wd_reg;
    if (~wd_count_en)
      wd_next = '0;
    else if (wd_reg != wd_limit_lp)
      wd_next = wd_reg + wd_width_lp'(1);
  end

  // Watchdog register and sticky timeout flag
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wd_reg      <= '0;
      timeout_reg <= 1'b0;
    end else begin
      wd_reg <= wd_next;
      if (wd_count_en & (wd_next == wd_limit_lp))
        timeout_reg <= 1'b1;
    end
  end

  assign timeout_err = timeout_reg;
`else
  localparam int unused_timeout_lp = timeout_p;
  assign timeout_err = 1'b0;
`endif

  assign credits_o                      = credits_reg;
  assign error_o[e_req_err_unexpected]  = unexpected_reg;
  assign error_o[e_req_err_timeout]     = timeout_err;

endmodule

// File: rtl/bp_cce_mem_requester.sv
// Initiator side of the cce_mem interface: turns ready/valid client requests
// into memory commands through a one-entry buffer, forwards responses straight
// back to the client, and bounds in-flight commands with a credit counter.
// Optional watchdog: define BP_CCE_MEM_REQUESTER_TIMEOUT_EN.
module bp_cce_mem_requester
  import bp_cce_mem_requester_pkg::*;
 #(parameter bp_params_e bp_params_p       = e_bp_default_cfg
  , parameter int         max_outstanding_p = 4
  , parameter int         timeout_p         = 1024
  , localparam bp_proc_param_s proc_param_lp   = bp_get_cfg(bp_params_p)
  , localparam int paddr_width_p             = proc_param_lp.paddr_width
  , localparam int cce_block_width_p         = proc_param_lp.cce_block_width
  , localparam int cce_mem_msg_width_lp      = $bits(bp_cce_mem_msg_s)
  , localparam int header_width_lp           = $bits(bp_cce_mem_msg_header_s)
  , localparam int size_width_lp             = $bits(bp_mem_msg_size_e)
  )
  (input  logic                            clk_i
  , input  logic                            reset_i
  , input  logic                            req_v_i
  , output logic                            req_ready_o
  , input  logic                            req_wr_i
  , input  logic [paddr_width_p-1:0]        req_addr_i
  , input  logic [size_width_lp-1:0]        req_size_i
  , input  logic [cce_block_width_p-1:0]    req_data_i
  , output logic [cce_mem_msg_width_lp-1:0] mem_cmd_o
  , output logic                            mem_cmd_v_o
  , input  logic                            mem_cmd_ready_i
  , input  logic [cce_mem_msg_width_lp-1:0] mem_resp_i
  , input  logic                            mem_resp_v_i
  , output logic                            mem_resp_yumi_o
  , output logic                            resp_v_o
  , output logic [header_width_lp-1:0]      resp_header_o
  , output logic [cce_block_width_p-1:0]    resp_data_o
  , input  logic                            resp_yumi_i
  , output logic                            idle_o
  , output logic [1:0]                      error_o
  );

  localparam int credit_width_lp = $clog2(max_outstanding_p + 1);
  localparam logic [credit_width_lp:0] max_lp = (credit_width_lp + 1)'(max_outstanding_p);

  bp_cce_mem_msg_s            cmd_reg, cmd_next;
  bp_cce_mem_msg_s            resp_msg;
  logic                       cmd_v_reg, cmd_v_next;
  logic                       cmd_send;
  logic                       req_accept;
  logic [credit_width_lp-1:0] credits;
  logic [credit_width_lp:0]   committed;

  assign mem_cmd_v_o = cmd_v_reg & ~reset_i;
  assign mem_cmd_o   = cmd_reg;
  assign cmd_send    = mem_cmd_v_o & mem_cmd_ready_i;

  // Commands already on the wire plus the one waiting in the buffer
  assign committed   = {1'b0, credits} + {{credit_width_lp{1'b0}}, cmd_v_reg};
  assign req_ready_o = ~reset_i & (~cmd_v_reg | cmd_send) & (committed < max_lp);
  assign req_accept  = req_v_i & req_ready_o;

  // Buffer update: a send frees the slot, an accept refills it in the same cycle
  always_comb begin
    cmd_v_next = cmd_v_reg;
    cmd_next   = cmd_reg;
    if (cmd_send)
      cmd_v_next = 1'b0;
    if (req_accept) begin
      cmd_v_next                = 1'b1;
      cmd_next.header.msg_type  = req_wr_i ? e_mem_msg_wr : e_mem_msg_rd;
      cmd_next.header.addr      = req_addr_i;
      cmd_next.header.size      = bp_mem_msg_size_e'(req_size_i);
      cmd_next.header.payload   = '0;
      cmd_next.data             = req_wr_i ? req_data_i : '0;
    end
  end

  // One-entry command buffer
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cmd_v_reg <= 1'b0;
      cmd_reg   <= '0;
    end else begin
      cmd_v_reg <= cmd_v_next;
      cmd_reg   <= cmd_next;
    end
  end

  // Responses pass straight through to the client
  assign resp_msg        = bp_cce_mem_msg_s'(mem_resp_i);
  assign resp_v_o        = mem_resp_v_i & ~reset_i;
  assign resp_header_o   = resp_msg.header;
  assign resp_data_o     = resp_msg.data;
  assign mem_resp_yumi_o = resp_yumi_i & resp_v_o;

  assign idle_o = reset_i | (~cmd_v_reg & (credits == '0));

  bp_cce_mem_requester_credits
   #(.max_outstanding_p(max_outstanding_p)
    ,.timeout_p(timeout_p)
    )
   u_credits
    (.clk_i(clk_i)
    ,.reset_i(reset_i)
    ,.send_i(cmd_send)
    ,.yumi_i(mem_resp_yumi_o)
    ,.resp_v_i(resp_v_o)
    ,.credits_o(credits)
    ,.error_o(error_o)
    );

endmodule
